bmd_64_wdma_engine: RTL and testbench
=====================================

Name: bmd_64_wdma_engine

Overview:
- Responder side of the write-DMA start/done handshake. It accepts a level-held start and a 40-bit host address from the write-DMA sequencing FSM.
- It splits one frame of FRAME_BYTES into PCIe posted memory-write requests. Each request is no larger than MAX_PAYLOAD and never crosses a 4 KB boundary.
- Requests go to the 64-bit TX TLP engine with a req/ack handshake. The block then waits for each TLP to be sent and pulses done when the whole frame is out.

Parameters:
FRAME_BYTES, 2048, bytes per frame; power of two, 128..4096.
MAX_PAYLOAD, 128, max TLP payload in bytes; power of two, 128..512.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
init_rst_i  in  1  synchronous soft reset, same effect as rst
wdma_start_i  in  1  frame request, level, held until done observed
wdma_addr_i  in  40  host byte address of frame; bits [1:0] ignored (treated 0)
wdma_done_o  out  1  one-cycle pulse: frame fully transmitted
req_o  out  1  TLP request valid
req_addr_o  out  40  DW-aligned host byte address of this TLP
req_len_dw_o  out  11  payload length in DW (1..MAX_PAYLOAD/4)
req_offset_o  out  11  DW offset of payload within frame buffer
req_64b_o  out  1  1 when req_addr_o[39:32] != 0 (4DW header)
req_ack_i  in  1  TX engine accepted request
tx_done_i  in  1  one-cycle pulse: accepted TLP fully sent
busy_o  out  1  high from frame accept to done pulse
frame_cnt_o  out  16  frames completed since reset, wraps

Behaviour:
- Reset (rst async, or init_rst_i sync) drives all outputs to 0, including req_addr_o, req_len_dw_o, req_offset_o and frame_cnt_o. State goes to IDLE. An in-flight frame is abandoned and no done pulse is issued.
- All outputs are registered.
- State machine:
  - IDLE -> REQ: when wdma_start_i=1. Capture cur_addr = {wdma_addr_i[39:2],2'b00}, remaining = FRAME_BYTES, offset = 0. Set busy_o.
  - REQ: req_o=1 with stable addr/len/offset/64b until the cycle req_ack_i=1. On ack: drop req_o next cycle, cur_addr += len*4, offset += len, remaining -= len*4, go to WAIT_SENT.
  - WAIT_SENT: on tx_done_i, go to REQ if remaining != 0, else go to DONE with wdma_done_o=1 for exactly one cycle, frame_cnt_o += 1, busy_o=0.
  - DONE: wait for wdma_start_i=0, then go to IDLE. A start still high in DONE must not launch a new frame; it is a re-arm requirement.
- Latency: start seen at edge t gives req_o=1 after edge t+1. tx_done_i of the last TLP at edge t gives wdma_done_o=1 after edge t+1. tx_done_i of a non-last TLP gives the next req_o one cycle later.
- Chunk length, computed combinationally from registered state and registered into req_len_dw_o on entry to REQ: len_bytes = min(MAX_PAYLOAD, remaining, 4096 - cur_addr[11:0]).
- Address arithmetic is full 40-bit. A carry out of bit 31 is legal and sets req_64b_o on later requests. Wrap at 2^40 is not detected.
- tx_done_i outside WAIT_SENT is ignored. req_ack_i outside REQ is ignored.
- One outstanding TLP at a time; no pipelining of requests.
- wdma_start_i dropping mid-frame is ignored; the frame completes.
- init_rst_i and tx_done_i in the same cycle: the reset wins.

Test Plan:
- Aligned frame: addr 0x00_1000_0000, MPS 128, ack and tx_done each 1 cycle after request -> 16 requests of len 32 DW, addrs 0x1000_0000..0x1000_0780 step 0x80, offsets 0..480 step 32, req_64b_o=0, one done pulse, frame_cnt_o=1.
- 4 KB split: addr 0x00_0000_0FC0 -> 17 requests. First is len 16 at 0xFC0. Then 15 of len 32 at 0x1000..0x1700. Last is len 16 at 0x1780 with offset 496. Done once.
- 64-bit: addr 0x12_0000_0000 -> all requests have req_64b_o=1 and req_addr_o[39:32]=0x12. Separately, addr 0x00_FFFF_FC00 -> the first 8 requests have req_64b_o=0 and the rest have req_64b_o=1 with req_addr_o[39:32]=0x01.
- Backpressure: req_ack_i held low 5 cycles -> req_o and all req fields stable for 5 cycles. tx_done_i delayed 10 cycles -> no new req until 1 cycle after it.
- Re-arm: start held high 20 cycles after done -> exactly one done pulse and no new req. Start low then high -> second frame runs, frame_cnt_o=2.
- Reset mid-operation: init_rst_i pulsed after the 5th ack -> next cycle req_o=0 and busy_o=0, no done pulse. The next start restarts at offset 0. Async rst asserted mid-cycle clears outputs without waiting for clk.

Source files
------------

// File: rtl/bmd_64_wdma_engine_if.sv
// Signal bundle between the write-DMA sequencer / TX TLP engine side and
// the write-DMA engine: frame start/done handshake, TLP request/ack
// handshake and status outputs.
interface bmd_64_wdma_engine_if;
    logic        wdma_start_i;
    logic [39:0] wdma_addr_i;
    logic        wdma_done_o;
    logic        req_o;
    logic [39:0] req_addr_o;
    logic [10:0] req_len_dw_o;
    logic [10:0] req_offset_o;
    logic        req_64b_o;
    logic        req_ack_i;
    logic        tx_done_i;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    // The DMA engine itself
    modport slave (
        input  wdma_start_i, wdma_addr_i, req_ack_i, tx_done_i,
        output wdma_done_o, req_o, req_addr_o, req_len_dw_o, req_offset_o,
               req_64b_o, busy_o, frame_cnt_o
    );

    // Sequencer plus TX engine environment driving the DMA engine
    modport master (
        output wdma_start_i, wdma_addr_i, req_ack_i, tx_done_i,
        input  wdma_done_o, req_o, req_addr_o, req_len_dw_o, req_offset_o,
               req_64b_o, busy_o, frame_cnt_o
    );
endinterface

// File: rtl/bmd_64_wdma_engine.sv
// Write-DMA engine: splits one frame into posted memory-write requests
// bounded by the max payload size and by 4 KB address boundaries, issues
// them one at a time to the TX TLP engine and pulses done when the last
// TLP of the frame has been sent.
module bmd_64_wdma_engine #(
    parameter int FRAME_BYTES = 2048,
    parameter int MAX_PAYLOAD = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_rst_i,
    bmd_64_wdma_engine_if.slave    bus
);

    localparam logic [12:0] FRAME_BYTES_C = 13'(FRAME_BYTES);
    localparam logic [12:0] MPS_C         = 13'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_SENT = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Chunk size in bytes: the smallest of max payload, bytes left in the
    // frame and bytes left before the next 4 KB boundary.
    function automatic logic [12:0] chunk_bytes(input logic [11:0] addr_lo,
                                                input logic [12:0] rem);
        logic [12:0] to_boundary;
        logic [12:0] len;
        to_boundary = 13'd4096 - {1'b0, addr_lo};
        if (rem < MPS_C) begin
            len = rem;
        end else begin
            len = MPS_C;
        end
        if (to_boundary < len) begin
            len = to_boundary;
        end else begin
            len = len;
        end
        return len;
    endfunction

    state_t      state_r;
    logic [39:0] cur_addr_r;
    logic [12:0] remaining_r;
    logic [10:0] offset_r;
    logic        done_r;
    logic        req_r;
    logic [39:0] req_addr_r;
    logic [10:0] req_len_dw_r;
    logic [10:0] req_offset_r;
    logic        req_64b_r;
    logic        busy_r;
    logic [15:0] frame_cnt_r;

    logic [39:0] start_addr_s;
    logic [12:0] first_len_s;
    logic [12:0] next_len_s;
    logic [12:0] acked_bytes_s;
    logic [39:0] next_addr_s;
    logic        unused_bits_s;

    // Chunk sizing for the first request (from the inputs) and for
    // follow-on requests (from registered frame state), plus ack update.
    always_comb begin
        start_addr_s  = {bus.wdma_addr_i[39:2], 2'b00};
        first_len_s   = chunk_bytes(start_addr_s[11:0], FRAME_BYTES_C);
        next_len_s    = chunk_bytes(cur_addr_r[11:0], remaining_r);
        acked_bytes_s = {req_len_dw_r, 2'b00};
        next_addr_s   = cur_addr_r + {27'd0, acked_bytes_s};
        unused_bits_s = ^{bus.wdma_addr_i[1:0], first_len_s[1:0], next_len_s[1:0]};
    end

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cur_addr_r   <= 40'd0;
            remaining_r  <= 13'd0;
            offset_r     <= 11'd0;
            done_r       <= 1'b0;
            req_r        <= 1'b0;
            req_addr_r   <= 40'd0;
            req_len_dw_r <= 11'd0;
            req_offset_r <= 11'd0;
            req_64b_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else if (init_rst_i) begin
            state_r      <= IDLE;
            cur_addr_r   <= 40'd0;
            remaining_r  <= 13'd0;
            offset_r     <= 11'd0;
            done_r       <= 1'b0;
            req_r        <= 1'b0;
            req_addr_r   <= 40'd0;
            req_len_dw_r <= 11'd0;
            req_offset_r <= 11'd0;
            req_64b_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.wdma_start_i) begin
                        state_r      <= REQ;
                        cur_addr_r   <= start_addr_s;
                        remaining_r  <= FRAME_BYTES_C;
                        offset_r     <= 11'd0;
                        busy_r       <= 1'b1;
                        req_r        <= 1'b1;
                        req_addr_r   <= start_addr_s;
                        req_len_dw_r <= first_len_s[12:2];
                        req_offset_r <= 11'd0;
                        req_64b_r    <= |start_addr_s[39:32];
                    end
                end
                REQ: begin
                    if (bus.req_ack_i) begin
                        req_r       <= 1'b0;
                        cur_addr_r  <= next_addr_s;
                        offset_r    <= offset_r + req_len_dw_r;
                        remaining_r <= remaining_r - acked_bytes_s;
                        state_r     <= WAIT_SENT;
                    end
                end
                WAIT_SENT: begin
                    if (bus.tx_done_i) begin
                        if (remaining_r != 13'd0) begin
                            state_r      <= REQ;
                            req_r        <= 1'b1;
                            req_addr_r   <= cur_addr_r;
                            req_len_dw_r <= next_len_s[12:2];
                            req_offset_r <= offset_r;
                            req_64b_r    <= |cur_addr_r[39:32];
                        end else begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        end
                    end
                end
                DONE: begin
                    // Start must be seen low before another frame is accepted.
                    if (!bus.wdma_start_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wdma_done_o  = done_r;
    assign bus.req_o        = req_r;
    assign bus.req_addr_o   = req_addr_r;
    assign bus.req_len_dw_o = req_len_dw_r;
    assign bus.req_offset_o = req_offset_r;
    assign bus.req_64b_o    = req_64b_r;
    assign bus.busy_o       = busy_r;
    assign bus.frame_cnt_o  = frame_cnt_r;

endmodule

// File: tb/tb_bmd_64_wdma_engine.sv
// Self-checking bench for bmd_64_wdma_engine: a frame model fills an
// expected-request queue when start is driven; a TX-engine responder pops
// and compares each request the DUT issues.
module tb_bmd_64_wdma_engine;

    localparam int FRAME = 2048;
    localparam int MPS   = 128;

    typedef struct {
        logic [39:0] addr;
        logic [10:0] len;
        logic [10:0] off;
        logic        b64;
    } exp_req_t;

    logic clk;
    logic rst;
    logic init_rst;

    bmd_64_wdma_engine_if bus ();

    bmd_64_wdma_engine #(.FRAME_BYTES(FRAME), .MAX_PAYLOAD(MPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_rst_i (init_rst),
        .bus        (bus)
    );

    exp_req_t    exp_q[$];
    int          checks;
    int          passes;
    int          n32;
    logic [39:0] first_addr;
    logic [10:0] first_len;
    logic [39:0] last_addr;
    logic [10:0] last_len;
    logic [10:0] last_off;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: expected request list for a frame starting at a.
    task automatic push_frame(input logic [39:0] a);
        exp_req_t    e;
        logic [39:0] cur;
        int          rem;
        int          len;
        int          off;
        int          tob;
        cur = {a[39:2], 2'b00};
        rem = FRAME;
        off = 0;
        while (rem > 0) begin
            tob = 4096 - int'(cur[11:0]);
            len = MPS;
            if (rem < len) len = rem;
            if (tob < len) len = tob;
            e.addr = cur;
            e.len  = 11'(len / 4);
            e.off  = 11'(off);
            e.b64  = (cur[39:32] != 8'h00);
            exp_q.push_back(e);
            cur = cur + 40'(len);
            off = off + len / 4;
            rem = rem - len;
        end
    endtask

    // TX-engine responder: serves requests until done (or stop_after acks).
    task automatic serve_frame(input int ack_dly, input int tx_dly,
                               input int stop_after, output int nreq);
        exp_req_t e;
        int       guard;
        bit       fin;
        nreq  = 0;
        fin   = 1'b0;
        guard = 0;
        while (!fin && guard < 5000) begin
            guard++;
            if (bus.wdma_done_o === 1'b1) begin
                fin = 1'b1;
            end else if (bus.req_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_req: got req addr=%h, wanted no request", bus.req_addr_o);
                end else begin
                    passes++;
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.req_addr_o !== e.addr || bus.req_len_dw_o !== e.len ||
                        bus.req_offset_o !== e.off || bus.req_64b_o !== e.b64) begin
                        $display("FAIL req_fields: got addr=%h len=%0d off=%0d b64=%b, wanted addr=%h len=%0d off=%0d b64=%b",
                                 bus.req_addr_o, bus.req_len_dw_o, bus.req_offset_o, bus.req_64b_o,
                                 e.addr, e.len, e.off, e.b64);
                    end else begin
                        passes++;
                    end
                end
                if (nreq == 0) begin
                    first_addr = bus.req_addr_o;
                    first_len  = bus.req_len_dw_o;
                end
                last_addr = bus.req_addr_o;
                last_len  = bus.req_len_dw_o;
                last_off  = bus.req_offset_o;
                if (bus.req_64b_o === 1'b0) n32++;
                for (int i = 0; i < ack_dly; i++) begin
                    step();
                    checks++;
                    if (bus.req_o !== 1'b1 || bus.req_addr_o !== last_addr ||
                        bus.req_len_dw_o !== last_len || bus.req_offset_o !== last_off) begin
                        $display("FAIL req_stable: got req=%b addr=%h len=%0d off=%0d, wanted req=1 addr=%h len=%0d off=%0d",
                                 bus.req_o, bus.req_addr_o, bus.req_len_dw_o, bus.req_offset_o,
                                 last_addr, last_len, last_off);
                    end else begin
                        passes++;
                    end
                end
                bus.req_ack_i = 1'b1;
                step();
                bus.req_ack_i = 1'b0;
                checks++;
                if (bus.req_o !== 1'b0) begin
                    $display("FAIL req_drop: got req_o=%b after ack, wanted 0", bus.req_o);
                end else begin
                    passes++;
                end
                nreq++;
                if (stop_after > 0 && nreq == stop_after) begin
                    fin = 1'b1;
                end else begin
                    for (int i = 0; i < tx_dly; i++) begin
                        step();
                        checks++;
                        if (bus.req_o !== 1'b0 || bus.wdma_done_o !== 1'b0) begin
                            $display("FAIL wait_sent_quiet: got req=%b done=%b, wanted 0/0",
                                     bus.req_o, bus.wdma_done_o);
                        end else begin
                            passes++;
                        end
                    end
                    bus.tx_done_i = 1'b1;
                    step();
                    bus.tx_done_i = 1'b0;
                    checks++;
                    if ((bus.req_o | bus.wdma_done_o) !== 1'b1) begin
                        $display("FAIL tx_done_latency: got req=%b done=%b one cycle after tx_done, wanted one of them 1",
                                 bus.req_o, bus.wdma_done_o);
                    end else begin
                        passes++;
                    end
                end
            end else begin
                step();
            end
        end
        if (!fin) begin
            checks++;
            $display("FAIL serve_timeout: got no done after %0d cycles, wanted done", guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.req_o !== 1'b0 || bus.wdma_done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.req_addr_o !== 40'd0 || bus.req_len_dw_o !== 11'd0 ||
            bus.req_offset_o !== 11'd0 || bus.req_64b_o !== 1'b0 || bus.frame_cnt_o !== 16'd0) begin
            $display("FAIL reset_state: got req=%b done=%b busy=%b addr=%h len=%0d off=%0d b64=%b cnt=%0d, wanted all 0",
                     bus.req_o, bus.wdma_done_o, bus.busy_o, bus.req_addr_o, bus.req_len_dw_o,
                     bus.req_offset_o, bus.req_64b_o, bus.frame_cnt_o);
        end else begin
            passes++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned();
        int n;
        n32 = 0;
        bus.wdma_addr_i  = 40'h00_1000_0000;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        checks++;
        if (bus.req_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            $display("FAIL start_latency: got req=%b busy=%b, wanted 1/1", bus.req_o, bus.busy_o);
        end else begin
            passes++;
        end
        serve_frame(0, 0, 0, n);
        checks++;
        if (n != 16 || exp_q.size() != 0) begin
            $display("FAIL aligned_count: got %0d reqs (%0d left), wanted 16 (0 left)", n, exp_q.size());
        end else begin
            passes++;
        end
        checks++;
        if (last_addr !== 40'h00_1000_0780 || last_off !== 11'd480 || n32 != 16) begin
            $display("FAIL aligned_last: got addr=%h off=%0d n32=%0d, wanted 1000_0780/480/16", last_addr, last_off, n32);
        end else begin
            passes++;
        end
        checks++;
        if (bus.frame_cnt_o !== 16'd1 || bus.busy_o !== 1'b0) begin
            $display("FAIL aligned_cnt: got cnt=%0d busy=%b, wanted 1/0", bus.frame_cnt_o, bus.busy_o);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
        checks++;
        if (bus.wdma_done_o !== 1'b0) begin
            $display("FAIL done_pulse_width: got done=%b second cycle, wanted 0", bus.wdma_done_o);
        end else begin
            passes++;
        end
    endtask

    task automatic test_split();
        int n;
        bus.wdma_addr_i  = 40'h00_0000_0FC0;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 0, n);
        checks++;
        if (n != 17 || first_addr !== 40'h0FC0 || first_len !== 11'd16) begin
            $display("FAIL split_first: got n=%0d addr=%h len=%0d, wanted 17/0fc0/16", n, first_addr, first_len);
        end else begin
            passes++;
        end
        checks++;
        if (last_addr !== 40'h1780 || last_len !== 11'd16 || last_off !== 11'd496) begin
            $display("FAIL split_last: got addr=%h len=%0d off=%0d, wanted 1780/16/496", last_addr, last_len, last_off);
        end else begin
            passes++;
        end
        checks++;
        if (bus.frame_cnt_o !== 16'd2) begin
            $display("FAIL split_cnt: got %0d, wanted 2", bus.frame_cnt_o);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
    endtask

    task automatic test_64b();
        int n;
        n32 = 0;
        bus.wdma_addr_i  = 40'h12_0000_0000;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 0, n);
        checks++;
        if (n32 != 0 || last_addr[39:32] !== 8'h12 || n != 16) begin
            $display("FAIL hi_addr: got n32=%0d hi=%h n=%0d, wanted 0/12/16", n32, last_addr[39:32], n);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
        n32 = 0;
        bus.wdma_addr_i  = 40'h00_FFFF_FC00;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 0, n);
        checks++;
        if (n32 != 8 || last_addr[39:32] !== 8'h01 || n != 16) begin
            $display("FAIL carry_32: got n32=%0d hi=%h n=%0d, wanted 8/01/16", n32, last_addr[39:32], n);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        int n;
        bus.wdma_addr_i  = 40'h00_2000_0003;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(5, 10, 0, n);
        checks++;
        if (n != 16 || exp_q.size() != 0) begin
            $display("FAIL bp_count: got %0d reqs, wanted 16", n);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
    endtask

    task automatic test_rearm();
        int n;
        int extra;
        init_rst = 1'b1;
        step();
        init_rst = 1'b0;
        checks++;
        if (bus.frame_cnt_o !== 16'd0) begin
            $display("FAIL soft_rst_cnt: got %0d, wanted 0", bus.frame_cnt_o);
        end else begin
            passes++;
        end
        bus.wdma_addr_i  = 40'h00_0001_0000;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 0, n);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.req_o !== 1'b0 || bus.wdma_done_o !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL rearm_hold: got %0d cycles with req/done while start held, wanted 0", extra);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 0, n);
        checks++;
        if (bus.frame_cnt_o !== 16'd2 || n != 16) begin
            $display("FAIL rearm_cnt: got cnt=%0d n=%0d, wanted 2/16", bus.frame_cnt_o, n);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        bus.wdma_addr_i  = 40'h00_3000_0000;
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        serve_frame(0, 0, 5, n);
        init_rst         = 1'b1;
        bus.tx_done_i    = 1'b1;
        bus.wdma_start_i = 1'b0;
        step();
        init_rst      = 1'b0;
        bus.tx_done_i = 1'b0;
        checks++;
        if (n != 5 || bus.req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.wdma_done_o !== 1'b0 ||
            bus.req_addr_o !== 40'd0 || bus.frame_cnt_o !== 16'd0) begin
            $display("FAIL mid_soft_rst: got n=%0d req=%b busy=%b done=%b addr=%h cnt=%0d, wanted 5/0/0/0/0/0",
                     n, bus.req_o, bus.busy_o, bus.wdma_done_o, bus.req_addr_o, bus.frame_cnt_o);
        end else begin
            passes++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.wdma_done_o !== 1'b0 || bus.req_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL mid_no_done: got %0d cycles with done/req after reset, wanted 0", bad);
        end else begin
            passes++;
        end
        exp_q.delete();
        push_frame(bus.wdma_addr_i);
        bus.wdma_start_i = 1'b1;
        step();
        checks++;
        if (bus.req_o !== 1'b1 || bus.req_offset_o !== 11'd0) begin
            $display("FAIL restart_offset: got req=%b off=%0d, wanted 1/0", bus.req_o, bus.req_offset_o);
        end else begin
            passes++;
        end
        serve_frame(0, 0, 0, n);
        checks++;
        if (n != 16 || bus.frame_cnt_o !== 16'd1) begin
            $display("FAIL restart_frame: got n=%0d cnt=%0d, wanted 16/1", n, bus.frame_cnt_o);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        bus.wdma_addr_i  = 40'h00_4000_0000;
        bus.wdma_start_i = 1'b1;
        step();
        checks++;
        if (bus.req_o !== 1'b1) begin
            $display("FAIL async_pre: got req=%b, wanted 1", bus.req_o);
        end else begin
            passes++;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.req_addr_o !== 40'd0 ||
            bus.frame_cnt_o !== 16'd0) begin
            $display("FAIL async_clear: got req=%b busy=%b addr=%h cnt=%0d before clock edge, wanted 0",
                     bus.req_o, bus.busy_o, bus.req_addr_o, bus.frame_cnt_o);
        end else begin
            passes++;
        end
        bus.wdma_start_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            $display("FAIL async_after: got req=%b busy=%b, wanted 0/0", bus.req_o, bus.busy_o);
        end else begin
            passes++;
        end
    endtask

    initial begin
        checks           = 0;
        passes           = 0;
        n32              = 0;
        rst              = 1'b1;
        init_rst         = 1'b0;
        bus.wdma_start_i = 1'b0;
        bus.wdma_addr_i  = 40'd0;
        bus.req_ack_i    = 1'b0;
        bus.tx_done_i    = 1'b0;
        test_reset();
        test_aligned();
        test_split();
        test_64b();
        test_backpressure();
        test_rearm();
        test_reset_mid();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
